ft_freeze_sequencer: RTL

//  FreezeTime run controller. Sequences the emulation window from the UART trigger levels (sim_start/sim_end/sim_proc).

---
 rtl/ft_pkg.sv | 15 +
 rtl/ft_rr_arbiter.sv | 42 ++++
 rtl/ft_freeze_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ft_pkg.sv
// Shared encodings for the FreezeTime run controller: emulation-window and freeze-arbiter states.
package ft_pkg;

    typedef enum logic [1:0] {
        FT_IDLE = 2'd0,
        FT_RUN  = 2'd1,
        FT_DONE = 2'd2
    } win_state_e;

    typedef enum logic {
        FT_OPEN  = 1'b0,
        FT_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ft_rr_arbiter.sv
// Combinational round-robin pick: first unmasked request at or after ptr wins (one-hot gnt plus its index).
module ft_rr_arbiter
    import ft_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    logic [NREQ-1:0] eff;

    assign eff = req & ~mask;

    // Rotating priority search starting at the pointer.
    always_comb begin
        int k;
        gnt   = {NREQ{1'b0}};
        idx   = {PW{1'b0}};
        valid = 1'b0;
        k     = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end else begin
            end
            if (!valid && eff[k]) begin
                gnt[k] = 1'b1;
                idx    = PW'(k);
                valid  = 1'b1;
            end else begin
            end
        end
    end

endmodule

// File: rtl/ft_freeze_sequencer.sv
// FreezeTime run controller: emulation window FSM, round-robin SoC freeze arbitration with
// forward-progress spacing and timeout, run/frozen cycle counters and a one-shot snapshot.
module ft_freeze_sequencer
    import ft_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int CW      = 32,
    parameter int MIN_RUN = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            sim_start,
    input  logic            sim_end,
    input  logic            sim_proc,
    input  logic [NREQ-1:0] freeze_req,
    output logic [NREQ-1:0] freeze_gnt,
    output logic            soc_clk_en,
    output logic [1:0]      win_state,
    output logic [CW-1:0]   cnt_run,
    output logic [CW-1:0]   cnt_frozen,
    output logic [CW-1:0]   snap_run,
    output logic            snap_valid,
    output logic            err_timeout
);

    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int MRW = $clog2(MIN_RUN + 1);
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [MRW-1:0] MR_SAT  = MRW'(MIN_RUN);
    localparam logic [TW-1:0]  T_LIM   = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : {TW{1'b0}};
    localparam logic [CW-1:0]  CNT_MAX = {CW{1'b1}};

    win_state_e      win_q, win_d;
    arb_state_e      arb_q, arb_d;
    logic [NREQ-1:0] gnt_q, gnt_d, mask_q, mask_d;
    logic            clk_en_q, clk_en_d, err_q, err_d;
    logic [PW-1:0]   ptr_q, ptr_d, winner_q, winner_d;
    logic [MRW-1:0]  minrun_q, minrun_d;
    logic [TW-1:0]   hold_q, hold_d;
    logic [CW-1:0]   cnt_run_q, cnt_run_d, cnt_frozen_q, cnt_frozen_d, snap_run_q, snap_run_d;
    logic            snap_valid_q, snap_valid_d, proc_q, proc_d;

    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            pick_valid;
    logic            timeout_hit;

    ft_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req   (freeze_req),
        .mask  (mask_q),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign timeout_hit = (TIMEOUT > 0) && (hold_q == T_LIM);

    // Window sequencing, run/frozen counters and the one-shot snapshot.
    always_comb begin
        win_d        = win_q;
        cnt_run_d    = cnt_run_q;
        cnt_frozen_d = cnt_frozen_q;
        snap_run_d   = snap_run_q;
        snap_valid_d = snap_valid_q;
        proc_d       = sim_proc;
        case (win_q)
            FT_IDLE: win_d = sim_start ? FT_RUN : FT_IDLE;
            FT_RUN:  win_d = sim_end ? FT_DONE : FT_RUN;
            FT_DONE: win_d = FT_DONE;
            default: win_d = FT_IDLE;
        endcase
        if (win_q == FT_RUN) begin
            if (clk_en_q) begin
                cnt_run_d = (cnt_run_q != CNT_MAX) ? cnt_run_q + CW'(1) : cnt_run_q;
            end else begin
                cnt_frozen_d = (cnt_frozen_q != CNT_MAX) ? cnt_frozen_q + CW'(1) : cnt_frozen_q;
            end
        end else begin
        end
        // Only the first rising edge inside RUN is captured; it takes the value before this cycle's increment.
        if (sim_proc && !proc_q && (win_q == FT_RUN) && !snap_valid_q) begin
            snap_run_d   = cnt_run_q;
            snap_valid_d = 1'b1;
        end else begin
        end
    end

    // Freeze arbitration: grant, release on request drop or timeout, forward-progress spacing.
    always_comb begin
        arb_d    = arb_q;
        gnt_d    = gnt_q;
        clk_en_d = clk_en_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        hold_d   = hold_q;
        err_d    = err_q;
        mask_d   = mask_q & freeze_req;
        if (clk_en_q && (minrun_q != MR_SAT)) begin
            minrun_d = minrun_q + MRW'(1);
        end else begin
            minrun_d = minrun_q;
        end
        case (arb_q)
            FT_OPEN: begin
                if (pick_valid && (minrun_q == MR_SAT)) begin
                    arb_d    = FT_GRANT;
                    gnt_d    = pick_gnt;
                    clk_en_d = 1'b0;
                    winner_d = pick_idx;
                    ptr_d    = (pick_idx == PW'(NREQ - 1)) ? {PW{1'b0}} : pick_idx + PW'(1);
                    hold_d   = {TW{1'b0}};
                end else begin
                end
            end
            FT_GRANT: begin
                hold_d = (hold_q != {TW{1'b1}}) ? hold_q + TW'(1) : hold_q;
                if (!freeze_req[winner_q] || timeout_hit) begin
                    arb_d    = FT_OPEN;
                    gnt_d    = {NREQ{1'b0}};
                    clk_en_d = 1'b1;
                    minrun_d = {MRW{1'b0}};
                    // A forced release masks the holder until it lets go of its request.
                    if (freeze_req[winner_q]) begin
                        err_d            = 1'b1;
                        mask_d[winner_q] = 1'b1;
                    end else begin
                    end
                end else begin
                end
            end
            default: begin
                arb_d    = FT_OPEN;
                gnt_d    = {NREQ{1'b0}};
                clk_en_d = 1'b1;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            win_q        <= FT_IDLE;
            arb_q        <= FT_OPEN;
            gnt_q        <= {NREQ{1'b0}};
            mask_q       <= {NREQ{1'b0}};
            clk_en_q     <= 1'b1;
            err_q        <= 1'b0;
            ptr_q        <= {PW{1'b0}};
            winner_q     <= {PW{1'b0}};
            minrun_q     <= MR_SAT;
            hold_q       <= {TW{1'b0}};
            cnt_run_q    <= {CW{1'b0}};
            cnt_frozen_q <= {CW{1'b0}};
            snap_run_q   <= {CW{1'b0}};
            snap_valid_q <= 1'b0;
            proc_q       <= 1'b0;
        end else begin
            win_q        <= win_d;
            arb_q        <= arb_d;
            gnt_q        <= gnt_d;
            mask_q       <= mask_d;
            clk_en_q     <= clk_en_d;
            err_q        <= err_d;
            ptr_q        <= ptr_d;
            winner_q     <= winner_d;
            minrun_q     <= minrun_d;
            hold_q       <= hold_d;
            cnt_run_q    <= cnt_run_d;
            cnt_frozen_q <= cnt_frozen_d;
            snap_run_q   <= snap_run_d;
            snap_valid_q <= snap_valid_d;
            proc_q       <= proc_d;
        end
    end

    assign freeze_gnt  = gnt_q;
    assign soc_clk_en  = clk_en_q;
    assign win_state   = win_q;
    assign cnt_run     = cnt_run_q;
    assign cnt_frozen  = cnt_frozen_q;
    assign snap_run    = snap_run_q;
    assign snap_valid  = snap_valid_q;
    assign err_timeout = err_q;

endmodule
